blk_mem_arbiter: RTL

//  Shares one single-port 2-cycle-latency block RAM (ena/wea/addra/dina/douta) between a write requester and a read requester.

---
 rtl/blk_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/blk_mem_arbiter.sv
// Shares one single-port, 2-cycle-latency block RAM between a write requester and a read requester.
// Optional macro BLK_MEM_ARB_WRITE_PRIORITY_EN: writes always win, instead of round-robin.
module blk_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  r_valid,
  output logic                  r_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  input  logic [DATA_WIDTH-1:0] mem_douta
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [DATA_WIDTH-1:0] r_fifo [RESP_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_v0;
  logic                  r_v1;

  logic                  w_rd_ok;
  logic                  w_grant_w;
  logic                  w_grant_r;
  logic                  w_push;
  logic                  w_pop;
  logic [CRD_W-1:0]      w_credit_used;

  // Every read in flight or buffered holds a FIFO slot; same-cycle pops are not credited.
  assign w_credit_used = CRD_W'(r_count) + CRD_W'(r_v0) + CRD_W'(r_v1);
  assign w_rd_ok       = r_valid && (w_credit_used < CRD_W'(RESP_DEPTH));

`ifdef BLK_MEM_ARB_WRITE_PRIORITY_EN
  always_comb begin
    w_grant_w = w_valid;
    w_grant_r = w_rd_ok && !w_valid;
  end
`else
  typedef enum logic {ARB_WRITE = 1'b0, ARB_READ = 1'b1} arb_side_e;

  arb_side_e r_rr_last;

  always_comb begin
    w_grant_w = 1'b0;
    w_grant_r = 1'b0;
    if (w_valid && w_rd_ok) begin
      w_grant_w = (r_rr_last == ARB_READ);
      w_grant_r = (r_rr_last == ARB_WRITE);
    end else begin
      w_grant_w = w_valid;
      w_grant_r = w_rd_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_last <= ARB_READ;
    end else if (w_grant_w) begin
      r_rr_last <= ARB_WRITE;
    end else if (w_grant_r) begin
      r_rr_last <= ARB_READ;
    end
  end
`endif

  assign w_ready   = w_grant_w;
  assign r_ready   = w_grant_r;
  assign mem_ena   = w_grant_w | w_grant_r | r_v0;
  assign mem_wea   = w_grant_w;
  assign mem_addra = w_grant_w ? w_addr : r_addr;
  assign mem_dina  = w_data;

  // Read tags advance only when the RAM pipeline advances (ena-gated).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else if (mem_ena) begin
      r_v0 <= w_grant_r;
      r_v1 <= r_v0;
    end else begin
      r_v1 <= 1'b0;
    end
  end

  assign w_push = r_v1;
  assign w_pop  = data_out_valid && data_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RESP_DEPTH); i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_douta;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out       = r_fifo[r_rd_ptr];
  assign data_out_valid = (r_count != '0);

endmodule
